// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder reusing one full_adder cell over WIDTH clocks
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH);
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [CW-1:0]    cnt;
    logic             carry, fa_s, fa_cout, accept, last;

    full_adder u_fa (.A(a_sh[0]), .B(b_sh[0]), .Cin(carry), .S(fa_s), .Cout(fa_cout));

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = state == RUN && cnt == CW'(WIDTH - 1);
    assign busy   = state == RUN;
    assign done   = state == DONE;

    always_comb begin
        state_nx = state;
        state_nx = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            S      <= '0;
            Cout   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_sh  <= A;
                b_sh  <= B;
                carry <= Cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                carry  <= fa_cout;
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                cnt    <= cnt + 1'b1;
            end
            // Outputs move only on the final bit so partial sums never leak out
            if (last) begin
                S    <= {fa_s, sum_sh[WIDTH-1:1]};
                Cout <= fa_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: table, directed and random checks of serial_adder at WIDTH 8 and 4
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, s8;
    logic start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
    logic [3:0] a4 = '0, b4 = '0, s4;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
    );
    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
        .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One WIDTH=8 add; poke re-pulses start with new operands mid-RUN, rst_at aborts via reset
    task automatic add8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [8:0] exp, input int poke, input int rst_at);
        logic [7:0] s_prev = s8;
        logic       c_prev = cout8;
        int dones = 0, d_at = 0, busyc = 0;
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (rst_at != 0 && e == rst_at + 1) begin
                check({nm, " abort_out"}, {busy8, done8, cout8, s8}, 32'h0);
                s_prev = '0;
                c_prev = 1'b0;
            end else if (done8) begin
                dones++;
                d_at = e;
                check({nm, " result"}, {cout8, s8}, exp);
                s_prev = s8;
                c_prev = cout8;
            end else begin
                check({nm, " hold"}, {cout8, s8}, {c_prev, s_prev});
            end
            if (busy8) busyc++;
            start8 = (e == poke);
            if (e == poke) begin
                a8 = 8'hFF;
                b8 = 8'hFF;
            end
            rst = (rst_at != 0 && e == rst_at);
        end
        if (rst_at == 0) begin
            check({nm, " done_count"}, dones, 1);
            check({nm, " done_latency"}, d_at, 9);
            check({nm, " busy_cycles"}, busyc, 8);
        end else begin
            check({nm, " no_done_after_abort"}, dones, 0);
        end
    endtask

    initial begin
        vt[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vt[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vt[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
        vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vt[5] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset8", {busy8, done8, cout8, s8}, 32'h0);
        check("reset4", {busy4, done4, cout4, s4}, 32'h0);

        foreach (vt[i])
            add8($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, {vt[i].cout, vt[i].s}, 0, 0);

        add8("ignore_start", 8'h10, 8'h20, 1'b0, 9'h030, 3, 0);
        add8("abort", 8'hFF, 8'hFF, 1'b0, 9'h1FE, 0, 4);
        add8("after_abort", 8'h02, 8'h03, 1'b0, 9'h005, 0, 0);

        // start held high: a new add is accepted straight out of every DONE cycle
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        for (int e = 1; e <= 27; e++) begin
            @(negedge clk);
            check($sformatf("held_done_c%0d", e), done8, (e % 9 == 0));
            check($sformatf("held_busy_c%0d", e), busy8, (e % 9 != 0));
            if (done8) check("held_result", {cout8, s8}, 9'h002);
        end
        start8 = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            add8($sformatf("rand%0d", i), ra, rb, rc, 9'(int'(ra) + int'(rb) + int'(rc)), 0, 0);
        end

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c); start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    repeat (4) @(negedge clk);
                    check($sformatf("w4_done_%0d_%0d_%0d", a, b, c), done4, 1);
                    check($sformatf("w4_sum_%0d_%0d_%0d", a, b, c), {cout4, s4}, a + b + c);
                end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
